// File: rtl/counter_top_pkg.sv
// counter_top_pkg: control-bit indices and hex glyph table shared by counter_top and its decoder.
`default_nettype none

package counter_top_pkg;

  localparam int HOLD_B = 0;
  localparam int DOWN_B = 1;
  localparam int LOAD_B = 2;
  localparam int CLR_B  = 3;
  localparam int NSEL_B = 5;

  // Entry 15 is leftmost; segment bit0 = a, active high.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] seg_lookup(input logic [3:0] digit);
    return SEG_LUT[digit];
  endfunction

endpackage

`default_nettype wire

// File: rtl/counter_top_seg7.sv
// counter_top_seg7: combinational 4-bit hex digit to 7-segment (a..g, active high) decoder.
`default_nettype none

module counter_top_seg7
  import counter_top_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  assign seg = seg_lookup(digit);

endmodule

`default_nettype wire

// File: rtl/counter_top.sv
// counter_top: 8-bit up/down counter with prescaler and wrap flag for the TinyTapeout user slot.
// Define COUNTER_TOP_SEVENSEG_EN to drive uo_out as a 7-segment digit plus wrap flag.
`default_nettype none

module counter_top
  import counter_top_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [15:0] DIV_LAST = 16'(DIV - 1);

  logic [7:0]  count;
  logic [15:0] prescale;
  logic        wrap;
  logic [7:0]  count_next;
  logic        step_wraps;

  assign count_next = ui_in[DOWN_B] ? count - 8'd1 : count + 8'd1;
  assign step_wraps = ui_in[DOWN_B] ? (count == 8'h00) : (count == 8'hFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= 8'h00;
      prescale <= 16'h0000;
      wrap     <= 1'b0;
    end else if (ena) begin
      wrap <= 1'b0;
      if (ui_in[CLR_B]) begin
        count    <= 8'h00;
        prescale <= 16'h0000;
      end else if (ui_in[LOAD_B]) begin
        count    <= uio_in;
        prescale <= 16'h0000;
      end else if (!ui_in[HOLD_B]) begin
        if (prescale == DIV_LAST) begin
          prescale <= 16'h0000;
          count    <= count_next;
          wrap     <= step_wraps;
        end else begin
          prescale <= prescale + 16'd1;
        end
      end
    end
  end

  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

`ifdef COUNTER_TOP_SEVENSEG_EN
  logic [3:0] digit;
  logic [6:0] seg;
  logic       unused_in;

  assign digit = ui_in[NSEL_B] ? count[7:4] : count[3:0];

  counter_top_seg7 u_seg7 (
    .digit (digit),
    .seg   (seg)
  );

  assign uo_out    = {wrap, seg};
  assign unused_in = ^{ui_in[7:6], ui_in[4]};
`else
  logic unused_in;

  assign uo_out    = count;
  // Flag and nibble select only reach the pins in the 7-segment build.
  assign unused_in = ^{ui_in[7:4], wrap};
`endif

endmodule

`default_nettype wire

// File: tb/tb_counter_top.sv
// tb_counter_top: directed stimulus for DIV=1 and DIV=4 instances, checked every cycle against a bench model.
`default_nettype none

module tb_counter_top;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo1, uio_out1, uio_oe1;
  logic [7:0] uo4, uio_out4, uio_oe4;

  int n_pass  = 0;
  int n_total = 0;
  bit compare_on = 1'b0;

  always #5 clk = ~clk;

  counter_top #(.DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo1), .uio_out(uio_out1), .uio_oe(uio_oe1)
  );

  counter_top #(.DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo4), .uio_out(uio_out4), .uio_oe(uio_oe4)
  );

  // Behavioural model: integer count, enabled-edge tick counter per instance.
  int m_cnt  [2];
  int m_tick [2];
  bit m_wrap [2];
  int divs   [2] = '{1, 4};
  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      automatic int nxt;
      if (!rst_n) begin
        m_cnt[i]  <= 0;
        m_tick[i] <= 0;
        m_wrap[i] <= 1'b0;
      end else if (ena) begin
        m_wrap[i] <= 1'b0;
        if (ui_in[3]) begin
          m_cnt[i]  <= 0;
          m_tick[i] <= 0;
        end else if (ui_in[2]) begin
          m_cnt[i]  <= int'(uio_in);
          m_tick[i] <= 0;
        end else if (!ui_in[0]) begin
          if (m_tick[i] + 1 == divs[i]) begin
            nxt = ui_in[1] ? m_cnt[i] - 1 : m_cnt[i] + 1;
            m_tick[i] <= 0;
            m_wrap[i] <= (nxt < 0) || (nxt > 255);
            m_cnt[i]  <= (nxt + 256) % 256;
          end else begin
            m_tick[i] <= m_tick[i] + 1;
          end
        end
      end
    end
  end

  function automatic logic [7:0] expect_out(int i);
`ifdef COUNTER_TOP_SEVENSEG_EN
    int nib;
    nib = ui_in[5] ? (m_cnt[i] / 16) : (m_cnt[i] % 16);
    return {m_wrap[i], glyph[nib]};
`else
    return 8'(m_cnt[i]);
`endif
  endfunction

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 8'h%02h, expected 8'h%02h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (compare_on) begin
      check("uo_out div1", uo1, expect_out(0));
      check("uo_out div4", uo4, expect_out(1));
      check("uio_out div1", uio_out1 | uio_oe1, 8'h00);
      check("uio_out div4", uio_out4 | uio_oe4, 8'h00);
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic set_ui(bit hold, bit down, bit load, bit clr, bit nsel);
    ui_in = 8'h00;
    ui_in[0] = hold;
    ui_in[1] = down;
    ui_in[2] = load;
    ui_in[3] = clr;
    ui_in[5] = nsel;
  endtask

`ifdef COUNTER_TOP_SEVENSEG_EN
  function automatic logic [7:0] shown(logic [7:0] cnt);
    return {1'b0, glyph[cnt[3:0]]};
  endfunction
`else
  function automatic logic [7:0] shown(logic [7:0] cnt);
    return cnt;
  endfunction
`endif

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    #1;
`ifdef COUNTER_TOP_SEVENSEG_EN
    check("reset div1", uo1, 8'h3F);
`else
    check("reset div1", uo1, 8'h00);
`endif
    check("reset model", expect_out(0), uo1);
    compare_on = 1'b1;
    tick(2);
    rst_n = 1'b1;

    // Free run: 300 enabled edges
    tick(300);
`ifndef COUNTER_TOP_SEVENSEG_EN
    check("free run 300 div1", uo1, 8'h2C);
    check("free run 300 div4", uo4, 8'h4B);
`endif
    check("model 300 div1", 8'(m_cnt[0]), 8'h2C);
    check("model 300 div4", 8'(m_cnt[1]), 8'h4B);

    // Up-wrap
    set_ui(0, 0, 1, 0, 0); uio_in = 8'hFE; tick(1);
    set_ui(0, 0, 0, 0, 0); tick(1);
    check("up to FF", uo1, shown(8'hFF));
    tick(1);
`ifdef COUNTER_TOP_SEVENSEG_EN
    check("up wrap flag", uo1, 8'hBF);
`else
    check("up wrap 00", uo1, 8'h00);
`endif
    tick(1);
    check("after wrap", uo1, shown(8'h01));

    // Down-wrap
    set_ui(0, 0, 1, 0, 0); uio_in = 8'h01; tick(1);
    set_ui(0, 1, 0, 0, 0); tick(1);
    check("down to 00", uo1, shown(8'h00));
    tick(1);
`ifdef COUNTER_TOP_SEVENSEG_EN
    check("down wrap flag", uo1, 8'hF1);
`else
    check("down wrap FF", uo1, 8'hFF);
`endif

    // Priority
    set_ui(0, 0, 1, 0, 0); uio_in = 8'hA5; tick(1);
    check("load A5", uo1, shown(8'hA5));
    set_ui(0, 0, 1, 1, 0); tick(1);
    check("clear beats load", uo1, shown(8'h00));
    set_ui(1, 0, 1, 0, 0); tick(1);
    check("load beats hold", uo1, shown(8'hA5));
    set_ui(1, 0, 0, 0, 0); tick(20);
    check("hold 20", uo1, shown(8'hA5));

    // Enable freeze
    set_ui(0, 0, 0, 0, 0); tick(3);
    ena = 1'b0; tick(10);
    check("frozen", uo1, shown(8'hA8));
    ena = 1'b1; tick(1);
    check("resume", uo1, shown(8'hA9));

    // Prescaler restarts on load
    set_ui(0, 0, 1, 0, 0); uio_in = 8'h10; tick(1);
    set_ui(0, 0, 0, 0, 0); tick(3);
    check("div4 3 edges", uo4, shown(8'h10));
    tick(1);
    check("div4 4th edge", uo4, shown(8'h11));

`ifdef COUNTER_TOP_SEVENSEG_EN
    set_ui(1, 0, 1, 0, 0); uio_in = 8'h3A; tick(1);
    check("seg low nibble", {1'b0, uo1[6:0]}, 8'h77);
    set_ui(1, 0, 0, 0, 1); #1;
    check("seg high nibble", {1'b0, uo1[6:0]}, 8'h4F);
    set_ui(0, 0, 0, 0, 0);
`endif

    // Asynchronous reset mid-cycle
    tick(5);
    #1 rst_n = 1'b0;
    #1;
    check("async reset div1", uo1, shown(8'h00));
    check("async reset div4", uo4, shown(8'h00));
    tick(2);
    rst_n = 1'b1;
    tick(5);
    check("post reset 5", uo1, shown(8'h05));
    check("post reset div4", uo4, shown(8'h01));

    compare_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
